// File: rtl/seq_core_write_back_stage.sv
// seq_core_write_back_stage
// Final pipeline stage of the sequential core. It picks either load data or the
// ALU result, drives the register-file write port from a pipeline register,
// stalls upstream while a load is outstanding, and turns taken jumps into a
// multi-cycle flush pulse that squashes the instructions arriving behind them.
module seq_core_write_back_stage #(
  parameter int D_SIZE       = 32,
  parameter int A_SIZE       = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int ZERO_REG_EN  = 0,
  parameter int CNT_SIZE     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_read,
  input  logic              in_write_en,
  input  logic [A_SIZE-1:0] in_dst,
  input  logic [D_SIZE-1:0] in_result,
  input  logic              in_pc_load,
  input  logic              in_pc_loadr,
  input  logic [D_SIZE-1:0] data_in,
  input  logic              data_valid,
  output logic              stall,
  output logic              wb_en,
  output logic [A_SIZE-1:0] wb_addr,
  output logic [D_SIZE-1:0] wb_data,
  output logic              pc_flush,
  output logic [CNT_SIZE-1:0] retired
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0]       FLUSH_LOAD = FW'(FLUSH_CYCLES);
  localparam logic [FW-1:0]       FLUSH_ONE  = FW'(1);
  localparam logic [CNT_SIZE-1:0] CNT_ONE    = CNT_SIZE'(1);

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [A_SIZE-1:0]   loadDst_q, loadDst_d;
  logic [FW-1:0]       flushCnt_q, flushCnt_d;
  logic                wbEn_q, wbEn_d;
  logic [A_SIZE-1:0]   wbAddr_q, wbAddr_d;
  logic [D_SIZE-1:0]   wbData_q, wbData_d;
  logic [CNT_SIZE-1:0] retired_q, retired_d;

  logic accept;
  logic take;
  logic loadDone;

  // Writes to register 0 are dropped when the core treats r0 as hard-wired zero.
  function automatic logic dstAllowed(input logic [A_SIZE-1:0] dst);
    return !((ZERO_REG_EN != 0) && (dst == '0));
  endfunction

  // An instruction is taken only when the stage is free and no flush is in progress.
  assign accept   = in_valid && (state_q == IDLE);
  assign take     = accept && !pc_flush;
  assign loadDone = (state_q == LOAD_WAIT) && data_valid;
  assign pc_flush = (flushCnt_q != '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: loads park in LOAD_WAIT until memory returns data.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take && in_read) begin
          state_d = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        if (data_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: upstream holds while a load is outstanding.
  always_comb begin
    stall = (state_q == LOAD_WAIT);
  end

  // Datapath next-state: write port, latched load destination, flush counter, retire count.
  always_comb begin
    loadDst_d  = loadDst_q;
    flushCnt_d = pc_flush ? (flushCnt_q - FLUSH_ONE) : flushCnt_q;
    wbEn_d     = 1'b0;
    wbAddr_d   = wbAddr_q;
    wbData_d   = '0;
    retired_d  = retired_q;

    if (take) begin
      if (in_pc_load || in_pc_loadr) begin
        flushCnt_d = FLUSH_LOAD;
      end
      if (in_read) begin
        loadDst_d = in_dst;
      end else begin
        retired_d = retired_q + CNT_ONE;
        if (in_write_en && dstAllowed(in_dst)) begin
          wbEn_d   = 1'b1;
          wbAddr_d = in_dst;
          wbData_d = in_result;
        end
      end
    end

    if (loadDone) begin
      retired_d = retired_q + CNT_ONE;
      if (dstAllowed(loadDst_q)) begin
        wbEn_d   = 1'b1;
        wbAddr_d = loadDst_q;
        wbData_d = data_in;
      end
    end
  end

  // Datapath registers; reset abandons any outstanding load without writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loadDst_q  <= '0;
      flushCnt_q <= '0;
      wbEn_q     <= 1'b0;
      wbAddr_q   <= '0;
      wbData_q   <= '0;
      retired_q  <= '0;
    end else begin
      loadDst_q  <= loadDst_d;
      flushCnt_q <= flushCnt_d;
      wbEn_q     <= wbEn_d;
      wbAddr_q   <= wbAddr_d;
      wbData_q   <= wbData_d;
      retired_q  <= retired_d;
    end
  end

  assign wb_en   = wbEn_q;
  assign wb_addr = wbAddr_q;
  assign wb_data = wbData_q;
  assign retired = retired_q;

endmodule
